// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RVCPU memory path: arbiter FSM states and the
// load/store control codes understood by the mem array and the core.
package rvcpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IM_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_t;

    localparam int CTRL_W   = 3;
    localparam int STREAK_W = 8;

    localparam logic [CTRL_W-1:0] RD_NONE  = 3'd0;
    localparam logic [CTRL_W-1:0] RD_LB    = 3'd1;
    localparam logic [CTRL_W-1:0] RD_LH    = 3'd2;
    localparam logic [CTRL_W-1:0] RD_LW    = 3'd3;
    localparam logic [CTRL_W-1:0] RD_LD    = 3'd4;
    localparam logic [CTRL_W-1:0] RD_LBU   = 3'd5;
    localparam logic [CTRL_W-1:0] RD_LHU   = 3'd6;
    localparam logic [CTRL_W-1:0] RD_WORDU = 3'd7;

    localparam logic [CTRL_W-1:0] WR_NONE  = 3'd0;
    localparam logic [CTRL_W-1:0] WR_SB    = 3'd1;
    localparam logic [CTRL_W-1:0] WR_SH    = 3'd2;
    localparam logic [CTRL_W-1:0] WR_SD    = 3'd3;
    localparam logic [CTRL_W-1:0] WR_SW    = 3'd4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and memory-side signals around the arbiter.
// Handshake: a requester holds *_req (and its fields) high until the cycle its
// one-cycle *_valid pulse appears; toward memory, mem_en is a one-cycle strobe,
// mem_* fields stay stable until the access ends, and mem_ack=1 completes it.
interface mem_port_arbiter_if;
    import rvcpu_mem_pkg::*;

    logic              im_req;
    logic [63:0]       im_addr;
    logic [31:0]       im_dout;
    logic              im_valid;

    logic              dm_req;
    logic [63:0]       dm_addr;
    logic [CTRL_W-1:0] dm_rd_ctrl;
    logic [CTRL_W-1:0] dm_wr_ctrl;
    logic [63:0]       dm_din;
    logic [63:0]       dm_dout;
    logic              dm_valid;

    logic              bus_err;

    logic              mem_en;
    logic [63:0]       mem_addr;
    logic [CTRL_W-1:0] mem_rd_ctrl;
    logic [CTRL_W-1:0] mem_wr_ctrl;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;
    logic              mem_ack;

    modport slave (
        input  im_req, im_addr,
        output im_dout, im_valid,
        input  dm_req, dm_addr, dm_rd_ctrl, dm_wr_ctrl, dm_din,
        output dm_dout, dm_valid,
        output bus_err,
        output mem_en, mem_addr, mem_rd_ctrl, mem_wr_ctrl, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport master (
        output im_req, im_addr,
        input  im_dout, im_valid,
        output dm_req, dm_addr, dm_rd_ctrl, dm_wr_ctrl, dm_din,
        input  dm_dout, dm_valid,
        input  bus_err,
        input  mem_en, mem_addr, mem_rd_ctrl, mem_wr_ctrl, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_port_arbiter_timer.sv
// Access timeout counter: clear loads zero, en counts up and saturates at
// TIMEOUT, expired flags that the limit has been reached.
module mem_req_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en && count != LIMIT) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LIMIT);
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises the RVCPU fetch and data ports onto one single-port memory with a
// variable-latency acknowledge, a data-streak limit and an access timeout.
module mem_port_arbiter
    import rvcpu_mem_pkg::*;
#(
    parameter int MAX_DM_STREAK = 4,
    parameter int TIMEOUT       = 64
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus,
    output arb_state_t          dbg_state,
    output logic [STREAK_W-1:0] dbg_dm_streak
);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

    arb_state_t          state, next_state;
    logic [STREAK_W-1:0] dm_streak;
    logic                grant_im, grant_dm;
    logic                busy, done_ack, done_timeout;
    logic                timer_expired;

    mem_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (grant_im || grant_dm),
        .en      (busy),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        grant_im     = 1'b0;
        grant_dm     = 1'b0;
        done_ack     = 1'b0;
        done_timeout = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE: begin
                // A waiting fetch wins only once the data port has used its streak.
                if (bus.im_req && (!bus.dm_req || dm_streak == STREAK_MAX)) begin
                    grant_im   = 1'b1;
                    next_state = IM_BUSY;
                end else if (bus.dm_req) begin
                    grant_dm   = 1'b1;
                    next_state = DM_BUSY;
                end
            end
            IM_BUSY, DM_BUSY: begin
                busy = 1'b1;
                if (bus.mem_ack) begin
                    done_ack   = 1'b1;
                    next_state = IDLE;
                end else if (timer_expired) begin
                    done_timeout = 1'b1;
                    next_state   = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dm_streak       <= '0;
            bus.mem_en      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_rd_ctrl <= RD_NONE;
            bus.mem_wr_ctrl <= WR_NONE;
            bus.mem_wdata   <= '0;
            bus.im_dout     <= '0;
            bus.dm_dout     <= '0;
            bus.im_valid    <= 1'b0;
            bus.dm_valid    <= 1'b0;
            bus.bus_err     <= 1'b0;
        end else begin
            bus.mem_en   <= grant_im || grant_dm;
            bus.im_valid <= (done_ack || done_timeout) && (state == IM_BUSY);
            bus.dm_valid <= (done_ack || done_timeout) && (state == DM_BUSY);
            bus.bus_err  <= done_timeout;

            if (grant_im) begin
                dm_streak       <= '0;
                bus.mem_addr    <= bus.im_addr;
                bus.mem_rd_ctrl <= RD_WORDU;
                bus.mem_wr_ctrl <= WR_NONE;
                bus.mem_wdata   <= '0;
            end else if (grant_dm) begin
                if (!bus.im_req) begin
                    dm_streak <= '0;
                end else if (dm_streak != STREAK_MAX) begin
                    dm_streak <= dm_streak + STREAK_W'(1);
                end
                bus.mem_addr    <= bus.dm_addr;
                bus.mem_rd_ctrl <= bus.dm_rd_ctrl;
                bus.mem_wr_ctrl <= bus.dm_wr_ctrl;
                bus.mem_wdata   <= bus.dm_din;
            end

            // A timed-out access returns zero data alongside bus_err.
            if (state == IM_BUSY && done_ack) begin
                bus.im_dout <= bus.mem_rdata[31:0];
            end else if (state == IM_BUSY && done_timeout) begin
                bus.im_dout <= '0;
            end
            if (state == DM_BUSY && done_ack) begin
                bus.dm_dout <= bus.mem_rdata;
            end else if (state == DM_BUSY && done_timeout) begin
                bus.dm_dout <= '0;
            end
        end
    end

    assign dbg_state     = state;
    assign dbg_dm_streak = dm_streak;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked
// every cycle against a transaction-level model of grants and completions.
module tb_mem_port_arbiter;
    import rvcpu_mem_pkg::*;

    localparam int TO   = 8;
    localparam int MAXS = 4;
    localparam int EW   = 98;   // {due[31:0], is_dm, err, data[63:0]}

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();
    arb_state_t          dbg_state;
    logic [STREAK_W-1:0] dbg_dm_streak;

    mem_port_arbiter #(.MAX_DM_STREAK(MAXS), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .dbg_state     (dbg_state),
        .dbg_dm_streak (dbg_dm_streak)
    );

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;

    // stimulus knobs
    int   im_prob = 0, dm_prob = 0, lat_max = 3, never_prob = 0, junk_prob = 0;
    int   force_lat = -1;
    bit   im_hold = 0, dm_hold = 0, rand_rdata = 1;
    logic [63:0] fx_rdata = '0;

    // reference model
    logic [EW-1:0]     exp_q[$];
    bit                m_busy = 0, m_who = 0;
    int                m_en_cyc = 0, m_ack_cyc = -1, m_streak = 0;
    logic [63:0]       m_addr = '0, m_wdata = '0, m_dm_dout = '0;
    logic [CTRL_W-1:0] m_rd = '0, m_wr = '0;
    logic [31:0]       m_im_dout = '0;

    // observations for directed scenarios
    int req_cyc_im = 0, req_cyc_dm = 0, en_cyc_obs = 0;
    int lat_im_obs = -1, lat_dm_obs = -1, to_obs = -1;
    bit err_obs = 0;
    bit g_log[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        logic [EW-1:0] e;
        logic [63:0]   rdata;
        bit            ev_im, ev_dm, ev_err, was_busy, ack, pick_im;
        int            lat;
        ev_im = 0; ev_dm = 0; ev_err = 0;
        if (exp_q.size() != 0 && int'(exp_q[0][97:66]) == cyc) begin
            e = exp_q.pop_front();
            ev_err = e[64];
            if (e[65]) begin ev_dm = 1; m_dm_dout = e[63:0]; end
            else begin ev_im = 1; m_im_dout = e[31:0]; end
        end

        check("mem_en", bus.mem_en, m_busy && cyc == m_en_cyc);
        check("mem_addr", bus.mem_addr, m_addr);
        check("mem_rd_ctrl", bus.mem_rd_ctrl, m_rd);
        check("mem_wr_ctrl", bus.mem_wr_ctrl, m_wr);
        check("mem_wdata", bus.mem_wdata, m_wdata);
        check("im_valid", bus.im_valid, ev_im);
        check("dm_valid", bus.dm_valid, ev_dm);
        check("bus_err", bus.bus_err, ev_err);
        check("im_dout", bus.im_dout, m_im_dout);
        check("dm_dout", bus.dm_dout, m_dm_dout);
        check("one_valid", bus.im_valid & bus.dm_valid, 0);
        check("streak_cap", dbg_dm_streak > STREAK_W'(MAXS), 0);

        if (bus.mem_en) begin
            en_cyc_obs = cyc;
            g_log.push_back(bus.mem_wr_ctrl != WR_NONE || bus.mem_rd_ctrl != RD_WORDU);
        end
        if (bus.im_valid) lat_im_obs = cyc - req_cyc_im;
        if (bus.dm_valid) begin
            lat_dm_obs = cyc - req_cyc_dm;
            to_obs     = cyc - en_cyc_obs;
            err_obs    = bus.bus_err;
        end

        // requesters: drop on completion, occasionally raise a new request
        was_busy = m_busy;
        if (ev_im && !im_hold) bus.im_req = 1'b0;
        if (ev_dm && !dm_hold) bus.dm_req = 1'b0;
        if (!bus.im_req && $urandom_range(99) < im_prob) begin
            bus.im_req  = 1'b1;
            bus.im_addr = {$urandom, $urandom} & ~64'h3;
            req_cyc_im  = cyc;
        end
        if (!bus.dm_req && $urandom_range(99) < dm_prob) begin
            bus.dm_req  = 1'b1;
            bus.dm_addr = {$urandom, $urandom};
            bus.dm_din  = {$urandom, $urandom};
            case ($urandom_range(2))
                0: begin bus.dm_rd_ctrl = 3'($urandom_range(7, 1)); bus.dm_wr_ctrl = WR_NONE; end
                1: begin bus.dm_rd_ctrl = RD_NONE; bus.dm_wr_ctrl = 3'($urandom_range(4, 1)); end
                default: begin bus.dm_rd_ctrl = RD_NONE; bus.dm_wr_ctrl = WR_NONE; end
            endcase
            req_cyc_dm = cyc;
        end

        // memory: ack at the scheduled cycle, else the access times out
        ack   = 0;
        rdata = rand_rdata ? {$urandom, $urandom} : fx_rdata;
        if (was_busy) begin
            if (cyc == m_ack_cyc) begin
                ack = 1;
                exp_q.push_back({32'(cyc + 1), m_who, 1'b0, m_who ? rdata : {32'b0, rdata[31:0]}});
                m_busy = 0;
            end else if (cyc == m_en_cyc + TO) begin
                exp_q.push_back({32'(cyc + 1), m_who, 1'b1, 64'b0});
                m_busy = 0;
            end
        end else if ($urandom_range(99) < junk_prob) begin
            ack = 1;
        end
        bus.mem_ack   = ack;
        bus.mem_rdata = rdata;

        // arbitration decision for a request seen while idle
        if (!was_busy && (bus.im_req || bus.dm_req)) begin
            pick_im = bus.im_req && (!bus.dm_req || m_streak == MAXS);
            m_who   = !pick_im;
            if (pick_im) begin
                m_addr = bus.im_addr; m_rd = RD_WORDU; m_wr = WR_NONE; m_wdata = '0;
                m_streak = 0;
            end else begin
                m_addr = bus.dm_addr; m_rd = bus.dm_rd_ctrl; m_wr = bus.dm_wr_ctrl; m_wdata = bus.dm_din;
                m_streak = bus.im_req ? ((m_streak < MAXS) ? m_streak + 1 : m_streak) : 0;
            end
            if (force_lat >= 0) lat = force_lat;
            else if ($urandom_range(99) < never_prob) lat = -1;
            else lat = int'($urandom_range(lat_max));
            m_busy    = 1;
            m_en_cyc  = cyc + 1;
            m_ack_cyc = (lat < 0) ? -1 : cyc + 1 + lat;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic apply_reset(input bit keep_im);
        rst = 1'b1;
        bus.im_req  = keep_im;
        bus.dm_req  = 1'b0;
        bus.mem_ack = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        if (keep_im) req_cyc_im = cyc;
        m_busy = 0; m_streak = 0; m_addr = '0; m_rd = '0; m_wr = '0; m_wdata = '0;
        m_im_dout = '0; m_dm_dout = '0;
        exp_q.delete();
        check("rst_state", dbg_state, IDLE);
        check("rst_streak", dbg_dm_streak, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.im_req = 0; bus.im_addr = '0; bus.dm_req = 0; bus.dm_addr = '0;
        bus.dm_rd_ctrl = '0; bus.dm_wr_ctrl = '0; bus.dm_din = '0;
        bus.mem_rdata = '0; bus.mem_ack = 0;
        apply_reset(0);
        apply_reset(0);
        run(2);

        // fetch only, ack one cycle after mem_en
        force_lat = 1; rand_rdata = 0; fx_rdata = 64'h00000000_00500093;
        bus.im_req = 1; bus.im_addr = 64'h100; req_cyc_im = cyc;
        run(6);
        check("fetch_lat", lat_im_obs, 3);
        check("fetch_dout", bus.im_dout, 32'h00500093);
        check("fetch_rd", bus.mem_rd_ctrl, RD_WORDU);

        // zero-latency ack for both ports
        force_lat = 0; fx_rdata = 64'h12345678_9abcdef0;
        bus.im_req = 1; bus.im_addr = 64'h104; req_cyc_im = cyc;
        run(4);
        check("zl_im_lat", lat_im_obs, 2);
        check("zl_im_dout", bus.im_dout, 32'h9abcdef0);
        bus.dm_req = 1; bus.dm_addr = 64'h40; bus.dm_rd_ctrl = RD_LD; bus.dm_wr_ctrl = WR_NONE;
        req_cyc_dm = cyc;
        run(4);
        check("zl_dm_lat", lat_dm_obs, 2);
        check("zl_dm_dout", bus.dm_dout, 64'h12345678_9abcdef0);

        // store passthrough with a 5-cycle ack delay
        force_lat = 5; rand_rdata = 1;
        bus.dm_req = 1; bus.dm_addr = 64'h2008; bus.dm_din = 64'hDEADBEEF_CAFEF00D;
        bus.dm_rd_ctrl = RD_NONE; bus.dm_wr_ctrl = 3'd3; req_cyc_dm = cyc;
        run(10);
        check("st_lat", lat_dm_obs, 7);
        check("st_wr", bus.mem_wr_ctrl, 3);
        check("st_wdata", bus.mem_wdata, 64'hDEADBEEF_CAFEF00D);
        check("st_addr", bus.mem_addr, 64'h2008);

        // timeout with stale acks arriving while idle
        force_lat = -1; never_prob = 100; junk_prob = 100;
        bus.dm_req = 1; bus.dm_addr = 64'h3000; bus.dm_rd_ctrl = RD_LD; bus.dm_wr_ctrl = WR_NONE;
        req_cyc_dm = cyc;
        run(16);
        check("to_delay", to_obs, TO + 1);
        check("to_err", err_obs, 1);
        check("to_dout", bus.dm_dout, 0);
        junk_prob = 0;

        // reset in the middle of a data access, fetch waiting
        bus.dm_req = 1; bus.dm_addr = 64'h4000; req_cyc_dm = cyc;
        run(3);
        bus.im_addr = 64'h200;
        apply_reset(1);
        never_prob = 0; force_lat = 0; lat_im_obs = -1;
        run(5);
        check("rst_im_lat", lat_im_obs, 2);

        // both ports requesting continuously
        apply_reset(0);
        force_lat = -1; lat_max = 3;
        bus.dm_addr = 64'h5000; bus.dm_din = 64'h1111; bus.dm_rd_ctrl = RD_NONE; bus.dm_wr_ctrl = WR_SD;
        bus.im_addr = 64'h300;
        im_hold = 1; dm_hold = 1; bus.im_req = 1; bus.dm_req = 1;
        g_log.delete();
        run(80);
        im_hold = 0; dm_hold = 0;
        run(20);
        check("sim_grants", g_log.size() >= 15, 1);
        for (int i = 0; i < 15 && i < g_log.size(); i++) check("sim_order", g_log[i], (i % 5) != 4);

        // random traffic including timeouts and stray acks
        im_prob = 30; dm_prob = 30; lat_max = 10; never_prob = 5; junk_prob = 20;
        run(2000);
        im_prob = 0; dm_prob = 0;
        run(40);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
